// File: rtl/spgd_metric_diff_if.sv
// Bus bundle between the SPGD metric differencer, the upstream averager,
// the actuator stage and the downstream consumer of the metric difference.
interface spgd_metric_diff_if #(
   parameter int ADC_WIDTH = 12
);
   logic                        enable;
   logic signed [ADC_WIDTH-1:0] avg_data;
   logic                        avg_done;
   logic                        avg_rst;
   logic                        pert_sign;
   logic signed [ADC_WIDTH:0]   diff_out;
   logic                        diff_valid;
   logic                        diff_ready;
   logic [15:0]                 pair_cnt;
   logic                        timeout_err;

   modport master (
      output enable, avg_data, avg_done, diff_ready,
      input  avg_rst, pert_sign, diff_out, diff_valid, pair_cnt, timeout_err
   );

   modport slave (
      input  enable, avg_data, avg_done, diff_ready,
      output avg_rst, pert_sign, diff_out, diff_valid, pair_cnt, timeout_err
   );
endinterface

// File: rtl/spgd_metric_diff.sv
// SPGD two-sided perturbation sequencer: measures J+ and J-, emits J+ - J-.
// Optional averaging watchdog enabled by defining SPGD_DIFF_TIMEOUT_EN.
module spgd_metric_diff #(
   parameter int ADC_WIDTH      = 12,
   parameter int SETTLE_CYCLES  = 64,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic              clk,
   input logic              rst_n,
   spgd_metric_diff_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      SET_PLUS,
      WAIT_PLUS,
      SET_MINUS,
      WAIT_MINUS,
      OUTPUT
   } state_t;

   localparam logic [15:0] SettleLast = 16'(SETTLE_CYCLES - 1);

   generate
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535 || TIMEOUT_CYCLES < 1 || ADC_WIDTH < 2) begin : g_param_check
         $error("spgd_metric_diff: illegal parameter value");
      end
   endgenerate

   state_t                      state_q, state_d;
   logic                        avg_rst_q, avg_rst_d;
   logic                        pert_sign_q, pert_sign_d;
   logic                        diff_valid_q, diff_valid_d;
   logic signed [ADC_WIDTH:0]   diff_out_q, diff_out_d;
   logic [15:0]                 pair_cnt_q, pair_cnt_d;
   logic signed [ADC_WIDTH-1:0] jplus_q, jplus_d;
   logic [15:0]                 settle_cnt_q, settle_cnt_d;
   logic                        done_prev_q, done_prev_d;
   logic                        done_rise;
   logic signed [ADC_WIDTH:0]   diff_calc;

`ifdef SPGD_DIFF_TIMEOUT_EN
   localparam int WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

   logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
   logic           timeout_err_q, timeout_err_d;
`endif

   // A done level already high when the averager leaves reset must not count as a rise.
   assign done_rise = bus.avg_done & ~done_prev_q;
   assign diff_calc = {jplus_q[ADC_WIDTH-1], jplus_q} - {bus.avg_data[ADC_WIDTH-1], bus.avg_data};

   always_comb begin
      state_d      = state_q;
      avg_rst_d    = avg_rst_q;
      pert_sign_d  = pert_sign_q;
      diff_valid_d = diff_valid_q;
      diff_out_d   = diff_out_q;
      pair_cnt_d   = pair_cnt_q;
      jplus_d      = jplus_q;
      settle_cnt_d = settle_cnt_q;
      done_prev_d  = avg_rst_q ? 1'b1 : bus.avg_done;
`ifdef SPGD_DIFF_TIMEOUT_EN
      wd_cnt_d      = wd_cnt_q;
      timeout_err_d = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            avg_rst_d    = 1'b1;
            diff_valid_d = 1'b0;
            if (bus.enable) begin
               state_d      = SET_PLUS;
               pert_sign_d  = 1'b0;
               settle_cnt_d = '0;
            end
         end

         SET_PLUS: begin
            avg_rst_d   = 1'b1;
            pert_sign_d = 1'b0;
            if (settle_cnt_q == SettleLast) begin
               state_d      = WAIT_PLUS;
               avg_rst_d    = 1'b0;
               settle_cnt_d = '0;
`ifdef SPGD_DIFF_TIMEOUT_EN
               wd_cnt_d     = '0;
`endif
            end else begin
               settle_cnt_d = settle_cnt_q + 16'd1;
            end
         end

         WAIT_PLUS: begin
            avg_rst_d = 1'b0;
            if (done_rise) begin
               jplus_d      = bus.avg_data;
               state_d      = SET_MINUS;
               avg_rst_d    = 1'b1;
               pert_sign_d  = 1'b1;
               settle_cnt_d = '0;
            end
`ifdef SPGD_DIFF_TIMEOUT_EN
            else if (wd_cnt_q == WdLast) begin
               timeout_err_d = 1'b1;
               jplus_d       = '0;
               avg_rst_d     = 1'b1;
               settle_cnt_d  = '0;
               pert_sign_d   = 1'b0;
               state_d       = bus.enable ? SET_PLUS : IDLE;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
`endif
         end

         SET_MINUS: begin
            avg_rst_d   = 1'b1;
            pert_sign_d = 1'b1;
            if (settle_cnt_q == SettleLast) begin
               state_d      = WAIT_MINUS;
               avg_rst_d    = 1'b0;
               settle_cnt_d = '0;
`ifdef SPGD_DIFF_TIMEOUT_EN
               wd_cnt_d     = '0;
`endif
            end else begin
               settle_cnt_d = settle_cnt_q + 16'd1;
            end
         end

         WAIT_MINUS: begin
            avg_rst_d = 1'b0;
            if (done_rise) begin
               diff_out_d   = diff_calc;
               diff_valid_d = 1'b1;
               state_d      = OUTPUT;
            end
`ifdef SPGD_DIFF_TIMEOUT_EN
            else if (wd_cnt_q == WdLast) begin
               timeout_err_d = 1'b1;
               jplus_d       = '0;
               avg_rst_d     = 1'b1;
               settle_cnt_d  = '0;
               pert_sign_d   = 1'b0;
               state_d       = bus.enable ? SET_PLUS : IDLE;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
`endif
         end

         OUTPUT: begin
            avg_rst_d = 1'b0;
            if (diff_valid_q && bus.diff_ready) begin
               diff_valid_d = 1'b0;
               pair_cnt_d   = pair_cnt_q + 16'd1;
               avg_rst_d    = 1'b1;
               settle_cnt_d = '0;
               if (bus.enable) begin
                  state_d     = SET_PLUS;
                  pert_sign_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d      = IDLE;
            avg_rst_d    = 1'b1;
            diff_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         avg_rst_q     <= 1'b1;
         pert_sign_q   <= 1'b0;
         diff_valid_q  <= 1'b0;
         diff_out_q    <= '0;
         pair_cnt_q    <= '0;
         jplus_q       <= '0;
         settle_cnt_q  <= '0;
         done_prev_q   <= 1'b1;
`ifdef SPGD_DIFF_TIMEOUT_EN
         wd_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         avg_rst_q     <= avg_rst_d;
         pert_sign_q   <= pert_sign_d;
         diff_valid_q  <= diff_valid_d;
         diff_out_q    <= diff_out_d;
         pair_cnt_q    <= pair_cnt_d;
         jplus_q       <= jplus_d;
         settle_cnt_q  <= settle_cnt_d;
         done_prev_q   <= done_prev_d;
`ifdef SPGD_DIFF_TIMEOUT_EN
         wd_cnt_q      <= wd_cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign bus.avg_rst    = avg_rst_q;
   assign bus.pert_sign  = pert_sign_q;
   assign bus.diff_valid = diff_valid_q;
   assign bus.diff_out   = diff_out_q;
   assign bus.pair_cnt   = pair_cnt_q;
`ifdef SPGD_DIFF_TIMEOUT_EN
   assign bus.timeout_err = timeout_err_q;
`else
   assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_spgd_metric_diff.sv
// Scoreboard bench for spgd_metric_diff: directed J+/J- pairs, stalls, enable drop,
// mid-pair reset and watchdog behaviour (SPGD_DIFF_TIMEOUT_EN selects the expectation).
module tb_spgd_metric_diff;

   localparam int ADC_WIDTH = 12;
   localparam int SETTLE    = 4;
   localparam int TIMEOUT   = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   spgd_metric_diff_if #(.ADC_WIDTH(ADC_WIDTH)) bus ();

   spgd_metric_diff #(
      .ADC_WIDTH     (ADC_WIDTH),
      .SETTLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [ADC_WIDTH:0] diff;
      logic [15:0]               cnt;
   } exp_t;

   exp_t        expQ[$];
   int          asserts     = 0;
   int          failures    = 0;
   logic [15:0] expPairCnt  = 16'd0;

   task automatic checkOutput(input string name, input logic signed [31:0] actual,
                              input logic signed [31:0] expected);
      asserts++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic failBound(input string name);
      asserts++;
      failures++;
      $display("[TB] FAIL %s: wait bound expired, got timeout, expected event", name);
   endtask

   // Monitor: every presented result is checked against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.diff_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            asserts++;
            failures++;
            $display("[TB] FAIL unexpected_valid: got diff_out %0d, expected no result", bus.diff_out);
         end else begin
            checkOutput("diff_out", bus.diff_out, expQ[0].diff);
            if (bus.diff_ready === 1'b1) begin
               checkOutput("pair_cnt_at_handshake", bus.pair_cnt, expQ[0].cnt);
               void'(expQ.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got simulation still running, expected completion");
      $fatal(1, "[TB] global timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic waitAvgRst(input logic level, input string name);
      bit seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.avg_rst === level) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) failBound(name);
   endtask

   task automatic waitPairCnt(input logic [15:0] target);
      bit seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.pair_cnt === target) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) failBound("pair_cnt_advance");
   endtask

   task automatic pulseDone(input int data);
      @(posedge clk);
      #1;
      bus.avg_data = ADC_WIDTH'(data);
      bus.avg_done = 1'b1;
      @(posedge clk);
      #1;
      bus.avg_done = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_avg_rst"}, bus.avg_rst, 1);
      checkOutput({tag, "_pert_sign"}, bus.pert_sign, 0);
      checkOutput({tag, "_diff_out"}, bus.diff_out, 0);
      checkOutput({tag, "_diff_valid"}, bus.diff_valid, 0);
      checkOutput({tag, "_pair_cnt"}, bus.pair_cnt, 0);
      checkOutput({tag, "_timeout_err"}, bus.timeout_err, 0);
   endtask

   // One full J+/J- pair with a hand-computed expected difference.
   task automatic applyStimulus(input int jp, input int jm, input int expDiff, input int stall,
                                input bit heldDone, input bit dropEnable, input bit expectRestart);
      int  n;
      exp_t e;
      waitAvgRst(1'b0, "enter_wait_plus");
      checkOutput("pert_sign_wait_plus", bus.pert_sign, 0);
      if (heldDone) begin
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("no_capture_on_held_done", bus.avg_rst, 0);
         end
         tick(1);
         bus.avg_done = 1'b0;
      end
      if (dropEnable) begin
         tick(1);
         bus.enable = 1'b0;
      end
      pulseDone(jp);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.avg_rst !== 1'b1) break;
         n++;
         if (n == 1) checkOutput("pert_sign_set_minus", bus.pert_sign, 1);
      end
      checkOutput("set_minus_len", n, SETTLE);
      checkOutput("pert_sign_wait_minus", bus.pert_sign, 1);
      tick(1);
      bus.diff_ready = (stall == 0);
      e.diff = (ADC_WIDTH + 1)'(expDiff);
      e.cnt  = expPairCnt;
      expQ.push_back(e);
      pulseDone(jm);
      if (stall > 0) begin
         bit seen = 1'b0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.diff_valid === 1'b1) begin
               seen = 1'b1;
               break;
            end
         end
         if (!seen) failBound("diff_valid_rise");
         for (int i = 0; i < stall; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("valid_held_stall", bus.diff_valid, 1);
            checkOutput("pair_cnt_held_stall", bus.pair_cnt, expPairCnt);
         end
         tick(1);
         bus.diff_ready = 1'b1;
      end
      expPairCnt = expPairCnt + 16'd1;
      waitPairCnt(expPairCnt);
      if (expectRestart) begin
         n = 0;
         for (int k = 0; k < 100; k++) begin
            if (bus.avg_rst !== 1'b1) break;
            n++;
            @(negedge clk);
         end
         checkOutput("set_plus_len", n, SETTLE);
         checkOutput("pair_cnt_single_inc", bus.pair_cnt, expPairCnt);
      end else begin
         tick(10);
         @(negedge clk);
         checkOutput("idle_avg_rst", bus.avg_rst, 1);
         checkOutput("idle_valid", bus.diff_valid, 0);
         checkOutput("idle_pair_cnt", bus.pair_cnt, expPairCnt);
      end
   endtask

   initial begin
      int idx;
      int rstAt;
      bus.enable     = 1'b0;
      bus.avg_data   = '0;
      bus.avg_done   = 1'b0;
      bus.diff_ready = 1'b0;
      rst_n          = 1'b0;
      tick(3);
      @(negedge clk);
      checkResetValues("reset");
      tick(1);
      rst_n = 1'b1;

      // Pair 1 starts with the averager done level already high.
      bus.avg_data = ADC_WIDTH'(7);
      bus.avg_done = 1'b1;
      tick(2);
      bus.enable = 1'b1;
      applyStimulus(100, -50, 150, 0, 1'b1, 1'b0, 1'b1);
      checkOutput("pair_cnt_after_first", bus.pair_cnt, 1);
      applyStimulus(2047, -2048, 4095, 0, 1'b0, 1'b0, 1'b1);
      applyStimulus(-2048, 2047, -4095, 20, 1'b0, 1'b0, 1'b1);
      applyStimulus(-1, 1, -2, 0, 1'b0, 1'b0, 1'b1);
      applyStimulus(500, 200, 300, 0, 1'b0, 1'b1, 1'b0);

      // Reset asserted while waiting for J-: partial pair discarded.
      tick(1);
      bus.enable = 1'b1;
      waitAvgRst(1'b0, "rst_test_wait_plus");
      pulseDone(55);
      waitAvgRst(1'b1, "rst_test_set_minus");
      waitAvgRst(1'b0, "rst_test_wait_minus");
      checkOutput("pert_sign_before_reset", bus.pert_sign, 1);
      tick(1);
      rst_n      = 1'b0;
      bus.enable = 1'b0;
      @(negedge clk);
      checkResetValues("midreset");
      expPairCnt = 16'd0;
      tick(2);
      rst_n = 1'b1;
      tick(10);
      @(negedge clk);
      checkOutput("post_reset_pair_cnt", bus.pair_cnt, 0);
      checkOutput("post_reset_valid", bus.diff_valid, 0);

      // Watchdog: no done rise in WAIT_PLUS.
      bus.enable = 1'b1;
      waitAvgRst(1'b0, "wd_wait_plus");
      idx   = 0;
      rstAt = 0;
      for (int i = 2; i <= 40; i++) begin
         @(negedge clk);
         if (idx == 0 && bus.timeout_err === 1'b1) begin
            idx   = i;
            rstAt = int'(bus.avg_rst);
         end
      end
`ifdef SPGD_DIFF_TIMEOUT_EN
      // 16 clocks in WAIT, the registered pulse shows in the cycle after.
      checkOutput("timeout_pulse_cycle", idx, TIMEOUT + 1);
      checkOutput("timeout_goes_set_plus", rstAt, 1);
`else
      checkOutput("no_timeout_pulse", idx, 0);
      checkOutput("still_waiting_avg_rst", bus.avg_rst, 0);
      checkOutput("still_waiting_pert", bus.pert_sign, 0);
`endif
      checkOutput("scoreboard_drained", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule

// File: doc/spgd_metric_diff.md
SPGD_METRIC_DIFF -- requirements
Module: spgd_metric_diff

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 12, the width of the signed averaged metric sample.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 64, the perturbation settle time in clocks (legal range 1..65535).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, the averaging watchdog limit in clocks; used only with SPGD_DIFF_TIMEOUT_EN.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous and active-low.
REQ-006 ENABLE  input  1  level; high = run perturbation pairs continuously.
REQ-007 AVG_DATA  input  ADC_WIDTH  signed averaged metric from the upstream averager.
REQ-008 AVG_DONE  input  1  upstream averager done level; a 0->1 transition marks a new AVG_DATA.
REQ-009 AVG_RST  output  1  active-high restart for the upstream averager.
REQ-010 PERT_SIGN  output  1  perturbation polarity to the actuator stage; 0 = +delta, 1 = -delta.
REQ-011 DIFF_OUT  output  ADC_WIDTH+1  signed J+ minus J-.
REQ-012 DIFF_VALID / DIFF_READY  output / input  1 / 1  valid-ready handshake for DIFF_OUT.
REQ-013 PAIR_CNT  output  16  count of completed handshakes; wraps 0xFFFF->0.
REQ-014 TIMEOUT_ERR  output  1  one-cycle pulse on watchdog expiry (tied 0 when the feature is out).

Function
REQ-015 SHALL implement states IDLE, SET_PLUS, WAIT_PLUS, SET_MINUS, WAIT_MINUS, OUTPUT.
REQ-016 IDLE: AVG_RST=1, DIFF_VALID=0; with ENABLE=1, SHALL enter SET_PLUS on the next edge.
REQ-017 SET_PLUS: PERT_SIGN=0, AVG_RST=1 for exactly SETTLE_CYCLES clocks, then SHALL enter WAIT_PLUS.
REQ-018 WAIT_PLUS: AVG_RST=0; on the first AVG_DONE rise, SHALL latch AVG_DATA into J+ and enter SET_MINUS.
REQ-019 SET_MINUS: PERT_SIGN=1, AVG_RST=1 for exactly SETTLE_CYCLES clocks, then SHALL enter WAIT_MINUS.
REQ-020 WAIT_MINUS: on the first AVG_DONE rise, SHALL register DIFF_OUT = sext(J+) - sext(AVG_DATA) at full ADC_WIDTH+1 width (no overflow possible), assert DIFF_VALID on the next cycle, and enter OUTPUT.
REQ-021 AVG_DONE rise detection SHALL use a registered copy of AVG_DONE that is forced to 1 while AVG_RST=1, so a level already high at WAIT entry is not a rise.
REQ-022 OUTPUT: DIFF_OUT and DIFF_VALID SHALL be held stable until DIFF_VALID and DIFF_READY are both high.
REQ-023 On handshake: DIFF_VALID=0 next cycle, PAIR_CNT+1, then SET_PLUS if ENABLE=1, else IDLE.
REQ-024 ENABLE falling mid-pair SHALL NOT abort; the current pair completes through OUTPUT, then IDLE.
REQ-025 PERT_SIGN SHALL hold its last value in the WAIT and OUTPUT states.
REQ-026 DIFF_READY held high during OUTPUT entry SHALL give a one-cycle DIFF_VALID pulse.

Reset
REQ-027 While RST_N=0: state=IDLE, AVG_RST=1, PERT_SIGN=0, DIFF_OUT=0, DIFF_VALID=0, PAIR_CNT=0, TIMEOUT_ERR=0, J+=0, settle/watchdog counters=0.
REQ-028 Reset assertion mid-operation SHALL abort immediately; a partial pair is discarded and no DIFF_VALID is issued.

Configuration
REQ-029 Macro SPGD_DIFF_TIMEOUT_EN defined: a watchdog SHALL count clocks in WAIT_PLUS/WAIT_MINUS; reaching TIMEOUT_CYCLES without an AVG_DONE rise SHALL pulse TIMEOUT_ERR for 1 cycle and go to SET_PLUS (or IDLE if ENABLE=0), discarding J+.
REQ-030 Macro SPGD_DIFF_TIMEOUT_EN undefined: no watchdog logic; WAIT states wait indefinitely; TIMEOUT_ERR constant 0.

Verification
REQ-031 SETTLE_CYCLES=4: ENABLE=1, AVG_DATA=100 at the first rise, -50 at the second rise -> PERT_SIGN 0 then 1; AVG_RST high exactly 4 clocks per SET state; DIFF_OUT=+150; DIFF_VALID=1; PAIR_CNT=1 after handshake.
REQ-032 Extremes, ADC_WIDTH=12: J+=2047, J-=-2048 -> DIFF_OUT=4095; J+=-2048, J-=2047 -> DIFF_OUT=-4095.
REQ-033 DIFF_READY=0 for 20 cycles in OUTPUT -> DIFF_OUT and DIFF_VALID stable; single PAIR_CNT increment on acceptance.
REQ-034 AVG_DONE held high from before WAIT_PLUS entry -> no capture until it falls and rises again.
REQ-035 ENABLE dropped in WAIT_PLUS -> pair completes, one handshake, then IDLE with AVG_RST=1; RST_N pulsed low in WAIT_MINUS -> all outputs at reset values, no DIFF_VALID.
REQ-036 With SPGD_DIFF_TIMEOUT_EN, TIMEOUT_CYCLES=16: no AVG_DONE rise -> TIMEOUT_ERR pulse at cycle 16 of WAIT, then SET_PLUS; without the macro -> remains in WAIT.
